// File: rtl/pipeline_pkg.sv
// Constants shared by the fetch and decode stages of the pipeline.
package pipeline_pkg;
    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'hE320F000;
    localparam logic [31:0] PC_STEP   = 32'd4;
endpackage

// File: rtl/fetch_hold_buffer.sv
// Captures the RAM read word on the first stalled edge so it survives the stall,
// and selects what the fetch stage presents to decode.
module fetch_hold_buffer
    import pipeline_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               resp_valid,
    input  logic [INSTR_W-1:0] rddata,
    output logic [INSTR_W-1:0] instr_out
);
    logic [INSTR_W-1:0] hold_instr;
    logic               hold_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_instr <= NOP_INSTR;
            hold_valid <= 1'b0;
        end else if (stall) begin
            // Only the first stalled edge sees the word for the presented PC.
            if (!hold_valid) begin
                hold_instr <= rddata;
                hold_valid <= 1'b1;
            end
        end else begin
            hold_valid <= 1'b0;
        end
    end

    assign instr_out = !resp_valid ? NOP_INSTR :
                       hold_valid  ? hold_instr : rddata;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC and branch tag, issues reads to a 1-cycle
// synchronous instruction memory and presents tagged instructions to decode.
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sel_stall,
    input  logic               sel_branch,
    input  logic [31:0]        branch_target,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               imem_rden,
    input  logic [INSTR_W-1:0] imem_rddata,
    output logic [INSTR_W-1:0] instr_out,
    output logic               branch_out,
    output logic [31:0]        pc_out,
    output logic               branch_ref
);
    logic [31:0] pc_reg, resp_pc, target_aligned;
    logic        tag, resp_tag, resp_valid;

    assign target_aligned = branch_target & ~32'h3;

    // A redirect overrides the stall so the tag flips in the branch cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= RESET_PC;
            tag    <= 1'b0;
        end else if (sel_branch) begin
            pc_reg <= target_aligned;
            tag    <= ~tag;
        end else if (!sel_stall) begin
            pc_reg <= pc_reg + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_pc    <= RESET_PC;
            resp_tag   <= 1'b0;
            resp_valid <= 1'b0;
        end else if (!sel_stall) begin
            resp_pc    <= pc_reg;
            resp_tag   <= tag;
            resp_valid <= 1'b1;
        end
    end

    assign imem_addr  = pc_reg[IMEM_AW+1:2];
    assign imem_rden  = rst_n;
    assign branch_out = resp_tag;
    assign pc_out     = resp_pc;
    assign branch_ref = tag;

    fetch_hold_buffer u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (sel_stall),
        .resp_valid (resp_valid),
        .rddata     (imem_rddata),
        .instr_out  (instr_out)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a cycle-level program-order model pushes the
// expected presented instruction each cycle; a monitor pops and compares.
module tb_fetch_unit;
    localparam int          AW      = 11;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP     = 32'hE320F000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sel_stall = 1'b0, sel_branch = 1'b0;
    logic [31:0] branch_target = '0;
    logic [AW-1:0] a_addr, w_addr;
    logic a_rden, w_rden, a_bout, w_bout, a_bref, w_bref;
    logic [31:0] a_rd, w_rd, a_instr, w_instr, a_pc, w_pc;
    logic w_stall = 1'b0, w_br = 1'b0;
    logic [31:0] w_tgt = '0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .sel_stall(sel_stall), .sel_branch(sel_branch),
        .branch_target(branch_target), .imem_addr(a_addr), .imem_rden(a_rden),
        .imem_rddata(a_rd), .instr_out(a_instr), .branch_out(a_bout),
        .pc_out(a_pc), .branch_ref(a_bref));

    fetch_unit #(.RESET_PC(WRAP_PC), .IMEM_AW(AW)) dut_w (
        .clk(clk), .rst_n(rst_n), .sel_stall(w_stall), .sel_branch(w_br),
        .branch_target(w_tgt), .imem_addr(w_addr), .imem_rden(w_rden),
        .imem_rddata(w_rd), .instr_out(w_instr), .branch_out(w_bout),
        .pc_out(w_pc), .branch_ref(w_bref));

    // Memory contents: mem[i] = 0x1000_0000 + i, synchronous read.
    function automatic logic [31:0] mem_word(input logic [31:0] byte_addr);
        return 32'h1000_0000 + {21'b0, byte_addr[AW+1:2]};
    endfunction

    always @(posedge clk) begin
        a_rd <= 32'h1000_0000 + {21'b0, a_addr};
        w_rd <= 32'h1000_0000 + {21'b0, w_addr};
    end

    // Model: the stage presents the word fetched at the last unstalled edge.
    typedef struct {
        logic [31:0] pc;
        logic        tag;
        logic        pv;
        logic [31:0] pinstr;
        logic [31:0] ppc;
        logic        ptag;
    } mstate_t;

    typedef struct {
        logic [31:0]   instr;
        logic [31:0]   pc;
        logic          btag;
        logic          bref;
        logic          rden;
        logic [AW-1:0] addr;
    } exp_t;

    mstate_t ma, mw;
    exp_t qa[$], qw[$];
    int vectors = 0;
    int miscompares = 0;
    bit done = 1'b0;

    task automatic model_step(inout mstate_t s, input logic [31:0] rpc,
                              input bit rst, input bit st, input bit br,
                              input logic [31:0] tgt, output exp_t e);
        if (!rst) begin
            s.pc = rpc; s.tag = 1'b0; s.pv = 1'b0; s.ppc = rpc; s.ptag = 1'b0;
            s.pinstr = NOP;
        end else begin
            if (!st) begin
                s.pv = 1'b1; s.pinstr = mem_word(s.pc); s.ppc = s.pc; s.ptag = s.tag;
            end
            if (br) begin
                s.pc  = {tgt[31:2], 2'b00};
                s.tag = ~s.tag;
            end else if (!st) begin
                s.pc = s.pc + 32'd4;
            end
        end
        e.instr = s.pv ? s.pinstr : NOP;
        e.pc    = s.ppc;
        e.btag  = s.ptag;
        e.bref  = s.tag;
        e.rden  = rst;
        e.addr  = s.pc[AW+1:2];
    endtask

    task automatic cyc(input bit r, input bit st, input bit b, input logic [31:0] t);
        exp_t ea, ew;
        @(negedge clk);
        rst_n = r; sel_stall = st; sel_branch = b; branch_target = t;
        model_step(ma, 32'h0, r, st, b, t, ea);
        model_step(mw, WRAP_PC, r, 1'b0, 1'b0, 32'h0, ew);
        qa.push_back(ea);
        qw.push_back(ew);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #2;
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("instr_out", a_instr, e.instr);
                chk("pc_out", a_pc, e.pc);
                chk("branch_out", {31'b0, a_bout}, {31'b0, e.btag});
                chk("branch_ref", {31'b0, a_bref}, {31'b0, e.bref});
                chk("imem_rden", {31'b0, a_rden}, {31'b0, e.rden});
                chk("imem_addr", {21'b0, a_addr}, {21'b0, e.addr});
            end
            if (qw.size() != 0) begin
                e = qw.pop_front();
                chk("wrap instr_out", w_instr, e.instr);
                chk("wrap pc_out", w_pc, e.pc);
                chk("wrap imem_addr", {21'b0, w_addr}, {21'b0, e.addr});
            end
        end
    end

    initial begin : stim
        int r;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);   // up to pc_out 0x14
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);   // stall on 0x14
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);   // 0x18, 0x1c, 0x20
        cyc(1, 0, 1, 32'h100);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 32'h200);
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 32'h103);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 32'h300);                          // back-to-back redirects
        cyc(1, 0, 1, 32'h404);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);                                // hold buffer now full
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            cyc((r < 2) ? 1'b0 : 1'b1,
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) == 0),
                $urandom);
        end
        cyc(1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #4;
        vectors++;
        if (qa.size() != 0 || qw.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", qa.size(), qw.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the decode pipeline register; it is the producer of that register's `instr_in` and `branch_in` inputs.
- Owns the PC and issues word reads to a synchronous-read instruction memory (1-cycle latency).
- Presents each returned instruction with its PC and a 1-bit branch tag.
- Owns the current branch tag (`branch_ref`). On a taken branch the tag toggles, so downstream stages squash in-flight wrong-path instructions to NOP.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of first fetch after reset (word aligned).
- IMEM_AW, 11, instruction memory word-address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- sel_stall  in  1  hazard-unit stall; 1 = hold PC and hold presented instruction
- sel_branch  in  1  taken branch / redirect from execute, single-cycle pulse
- branch_target  in  32  redirect byte address; bits [1:0] ignored
- imem_addr  out  IMEM_AW  word address to instruction memory (= pc_reg[IMEM_AW+1:2])
- imem_rden  out  1  read enable
- imem_rddata  in  32  read data, valid one cycle after address
- instr_out  out  32  instruction to decode stage (`instr_in`)
- branch_out  out  1  tag of instr_out (decode `branch_in`)
- pc_out  out  32  byte address of instr_out
- branch_ref  out  1  current branch tag (decode `branch_ref`)

Behaviour:
- Reset is asynchronous, active-low (`rst_n`); clock is `clk`.
- Reset values:
  - pc_reg = RESET_PC, tag = 0, resp_valid = 0, hold_valid = 0.
  - Outputs: instr_out = NOP (32'hE320F000), branch_out = 0, pc_out = RESET_PC, branch_ref = 0.
  - imem_rden = 0 while rst_n = 0, otherwise 1.
- Issue: every cycle imem_addr = pc_reg (combinational). Re-issuing the same address during a stall is legal (read is idempotent).
- Response metadata:
  - Registers resp_pc, resp_tag, resp_valid.
  - On an unstalled edge: resp_pc <= pc_reg, resp_tag <= tag, resp_valid <= 1.
  - On a stalled edge: all three hold.
- PC update, priority order:
  1. sel_branch: pc_reg <= {branch_target[31:2], 2'b00}, tag <= ~tag. This applies even when stalled.
  2. Else if !sel_stall: pc_reg <= pc_reg + 4, wrapping modulo 2^32.
  3. Else pc_reg holds.
- Hold buffer (preserves the RAM word across a stall):
  - Edge with sel_stall = 1 and hold_valid = 0: hold_instr <= imem_rddata, hold_valid <= 1.
  - Edge with sel_stall = 0: hold_valid <= 0.
  - Edge with sel_stall = 1 and hold_valid = 1: hold_instr holds.
- Output mux (combinational from registers):
  - instr_out = !resp_valid ? NOP : hold_valid ? hold_instr : imem_rddata.
  - branch_out = resp_tag; pc_out = resp_pc; branch_ref = tag.
- Latency: an address issued in cycle N appears on instr_out in cycle N+1. Steady-state throughput is one instruction per cycle.
- Branch flush:
  - In the redirect cycle, the presented instruction carries the old tag.
  - The instruction issued in the redirect cycle (old PC, old tag) appears next.
  - Both mismatch the new branch_ref, so the decode stage turns them into NOPs.
  - The target instruction appears 2 cycles after sel_branch, carrying the new tag.
- Branch during stall: the hold buffer keeps old-tag content, so it is squashed downstream. After the stall releases, the first newly captured response is the target.
- Consecutive branches: each pulse toggles the tag; the last target wins.
- Reset mid-operation: all state returns to reset values immediately. The first valid instruction is mem[RESET_PC] in the second cycle after rst_n deasserts.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - NOP_INSTR = 32'hE320F000, also used by the decode stage.
  - INSTR_W = 32.
  - PC_STEP = 4.
- Natural sub-module: fetch_hold_buffer, covering the hold_instr/hold_valid capture and the output mux. The PC/tag logic stays in the top.

Test Plan:
- Reset, memory mem[i] = 32'h1000_0000 + i, RESET_PC = 0 -> instr_out = NOP, branch_ref = 0; after release, cycle 2 shows 32'h1000_0000 / pc_out 0, then 32'h1000_0001 / pc_out 4, one per cycle.
- Stall for 3 cycles while 32'h1000_0005 (pc 0x14) is presented -> instr_out and pc_out stay 0x14's word for all stalled cycles; after release the next word is 32'h1000_0006 / 0x18, with none skipped or duplicated.
- sel_branch with target 0x100 while pc_out = 0x20 -> branch_ref toggles to 1; the next two presented words carry branch_out = 0; the third is mem[0x40] at pc_out 0x100 with branch_out = 1.
- Branch asserted during a stall, target 0x200 -> held word keeps branch_out = old tag; after release, mem[0x80] appears with the new tag.
- Target 0x103 -> fetch from 0x100. Set RESET_PC near the top of memory and run 2 words -> PC wraps modulo 2^32 with no X on outputs.
- Assert rst_n low mid-stream with hold_valid = 1 -> outputs return immediately to NOP / RESET_PC / tag 0, and hold_valid clears.
